// File: rtl/usb_fifo_sched.sv
// FX2LP slave-FIFO scheduler: time-shares the FD bus between draining EP2 OUT
// and filling EP6 IN, with round-robin grants and bursts bounded by BURST_MAX.
`timescale 1ns/1ps

module usb_fifo_sched #(
  parameter int unsigned BURST_MAX = 256
) (
  input  logic        CLKOUT,
  input  logic        rst_n,
  input  logic        FLAGA,
  input  logic        FLAGD,
  output logic        SLRD,
  output logic        SLWR,
  output logic        SLOE,
  output logic        PKTEND,
  output logic [1:0]  FIFOADR,
  input  logic [15:0] FD_i,
  output logic [15:0] FD_o,
  output logic        FD_oe,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        tx_flush
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL_RD,
    S_RD_OE,
    S_READ,
    S_SEL_WR,
    S_WRITE,
    S_PKTEND
  } state_e;

  localparam logic [1:0]  ADDR_EP2  = 2'b00;
  localparam logic [1:0]  ADDR_EP6  = 2'b10;
  localparam logic [16:0] BURST_LIM = 17'(BURST_MAX);

  state_e      state_q, state_d;
  logic        last_wr_q, last_wr_d;
  logic        flush_pend_q, flush_pend_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  fifoadr_q, fifoadr_d;

  logic        rd_req, wr_req;
  logic [16:0] count_inc;
  logic        burst_done;

  assign rd_req     = FLAGA;
  assign wr_req     = tx_valid | flush_pend_q;
  assign count_inc  = {1'b0, count_q} + 17'd1;
  assign burst_done = (count_inc == BURST_LIM);
  assign FIFOADR    = fifoadr_q;

  // A flush arriving in the very cycle PKTEND retires the old one must survive.
  assign flush_pend_d = tx_flush | (flush_pend_q & (state_q != S_PKTEND));

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d   = state_q;
    last_wr_d = last_wr_q;
    fifoadr_d = fifoadr_q;
    count_d   = count_q;
    SLRD      = 1'b1;
    SLWR      = 1'b1;
    SLOE      = 1'b1;
    PKTEND    = 1'b1;
    FD_oe     = 1'b0;
    FD_o      = '0;
    rx_data   = '0;
    rx_valid  = 1'b0;
    tx_ready  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Contended grant goes to the side that did not win last time.
        if (rd_req && (!wr_req || last_wr_q)) begin
          state_d   = S_SEL_RD;
          last_wr_d = 1'b0;
          fifoadr_d = ADDR_EP2;
          count_d   = '0;
        end else if (wr_req) begin
          state_d   = S_SEL_WR;
          last_wr_d = 1'b1;
          fifoadr_d = ADDR_EP6;
          count_d   = '0;
        end
      end

      S_SEL_RD: state_d = S_RD_OE;

      S_RD_OE: begin
        SLOE    = 1'b0;
        state_d = S_READ;
      end

      S_READ: begin
        SLOE     = 1'b0;
        rx_data  = FD_i;
        rx_valid = FLAGA;
        SLRD     = ~(FLAGA & rx_ready);
        if (!FLAGA) begin
          state_d = S_IDLE;
        end else if (rx_ready) begin
          count_d = count_inc[15:0];
          if (burst_done) state_d = S_IDLE;
        end
      end

      S_SEL_WR: state_d = S_WRITE;

      S_WRITE: begin
        FD_oe    = 1'b1;
        FD_o     = tx_data;
        tx_ready = FLAGD;
        SLWR     = ~(tx_valid & FLAGD);
        if (!FLAGD) begin
          state_d = S_IDLE;
        end else if (tx_valid) begin
          count_d = count_inc[15:0];
          if (burst_done) state_d = S_IDLE;
        end else begin
          state_d = flush_pend_q ? S_PKTEND : S_IDLE;
        end
      end

      S_PKTEND: begin
        FD_oe   = 1'b1;
        PKTEND  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode from state_q, so an async reset releases them immediately.
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_wr_q    <= 1'b1;
      flush_pend_q <= 1'b0;
      count_q      <= '0;
      fifoadr_q    <= ADDR_EP2;
    end else begin
      // NOTE: non-blocking here so every register samples pre-edge values.
      state_q      <= state_d;
      last_wr_q    <= last_wr_d;
      flush_pend_q <= flush_pend_d;
      count_q      <= count_d;
      fifoadr_q    <= fifoadr_d;
    end
  end

endmodule

// File: tb/tb_usb_fifo_sched.sv
// Self-checking bench for usb_fifo_sched: FX2 FIFO and core stream models,
// a grant/phase reference model compared every cycle, and directed scenarios.
`timescale 1ns/1ps

module tb_usb_fifo_sched;

  localparam int BMAX = 4;
  localparam int M_IDLE = 0, M_RD = 1, M_WR = 2, M_PK = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        FLAGA, FLAGD;
  logic        SLRD, SLWR, SLOE, PKTEND;
  logic [1:0]  FIFOADR;
  logic [15:0] FD_i, FD_o;
  logic        FD_oe;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready, tx_flush;

  usb_fifo_sched #(.BURST_MAX(BMAX)) dut (
    .CLKOUT(clk), .rst_n(rst_n), .FLAGA(FLAGA), .FLAGD(FLAGD),
    .SLRD(SLRD), .SLWR(SLWR), .SLOE(SLOE), .PKTEND(PKTEND), .FIFOADR(FIFOADR),
    .FD_i(FD_i), .FD_o(FD_o), .FD_oe(FD_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flush(tx_flush)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment knobs and observed traffic.
  logic [15:0] ep2_q[$];
  logic [15:0] tx_q[$];
  logic [15:0] rx_got[$];
  logic [15:0] ep6_got[$];
  int          pkt_marks[$];
  logic [1:0]  pkt_addr[$];
  bit          dir_log[$];
  int          rd_runs[$];
  int          ep6_space = 64;
  bit          rdy_toggle = 0, rdy_level = 1, tx_en = 1, flush_req = 0;
  int          rd_strobes = 0, wr_strobes = 0, cur_run = 0;
  logic [31:0] cyc = 0;

  bit          cap_rd, cap_rx, cap_wr, cap_tx, cap_pk, cap_sloe;
  logic [15:0] cap_rx_data, cap_fd;
  logic [1:0]  cap_addr;

  // Reference model: current grant direction and cycles elapsed since grant.
  int          m_dir, m_age, m_words;
  bit          m_last_wr, m_flush;
  logic [1:0]  m_addr;

  task automatic model_reset();
    m_dir = M_IDLE; m_age = 0; m_words = 0;
    m_last_wr = 1'b1; m_flush = 1'b0; m_addr = 2'b00;
    cur_run = 0;
  endtask

  task automatic model_compare();
    logic e_slrd, e_slwr, e_sloe, e_pk, e_oe, e_rxv, e_txr;
    e_slrd = 1; e_slwr = 1; e_sloe = 1; e_pk = 1; e_oe = 0; e_rxv = 0; e_txr = 0;
    case (m_dir)
      M_RD: begin
        if (m_age >= 1) e_sloe = 0;
        if (m_age >= 2) begin
          e_rxv  = FLAGA;
          e_slrd = !(FLAGA && rx_ready);
        end
      end
      M_WR: if (m_age >= 1) begin
        e_oe   = 1;
        e_txr  = FLAGD;
        e_slwr = !(tx_valid && FLAGD);
      end
      M_PK: begin
        e_oe = 1;
        e_pk = 0;
      end
      default: ;
    endcase
    check("cycle_outputs", {SLRD, SLWR, SLOE, PKTEND, FD_oe, rx_valid, tx_ready, FIFOADR},
          {e_slrd, e_slwr, e_sloe, e_pk, e_oe, e_rxv, e_txr, m_addr});
    check("cycle_no_bus_fight", !SLOE && FD_oe, 0);
    if (e_rxv) check("cycle_rx_data", rx_data, FD_i);
    if (m_dir == M_WR && m_age >= 1) check("cycle_fd_o", FD_o, tx_data);
  endtask

  task automatic model_advance();
    bit new_flush, rq, wq;
    new_flush = tx_flush || (m_flush && m_dir != M_PK);
    case (m_dir)
      M_IDLE: begin
        rq = FLAGA;
        wq = tx_valid || m_flush;
        if (rq && (!wq || m_last_wr)) begin
          m_dir = M_RD; m_age = 0; m_words = 0; m_last_wr = 0; m_addr = 2'b00;
        end else if (wq) begin
          m_dir = M_WR; m_age = 0; m_words = 0; m_last_wr = 1; m_addr = 2'b10;
        end
      end
      M_RD: begin
        if (m_age < 2) m_age++;
        else if (!FLAGA) m_dir = M_IDLE;
        else if (rx_ready) begin
          m_words++;
          if (m_words == BMAX) m_dir = M_IDLE;
        end
      end
      M_WR: begin
        if (m_age == 0) m_age = 1;
        else if (!FLAGD) m_dir = M_IDLE;
        else if (tx_valid) begin
          m_words++;
          if (m_words == BMAX) m_dir = M_IDLE;
        end else m_dir = m_flush ? M_PK : M_IDLE;
      end
      default: m_dir = M_IDLE;
    endcase
    m_flush = new_flush;
  endtask

  // Sole driver of the DUT's FIFO/core inputs; compares at each falling edge.
  initial begin
    FLAGA = 0; FLAGD = 0; FD_i = '0; rx_ready = 0; tx_data = '0; tx_valid = 0; tx_flush = 0;
    cap_rd = 0; cap_rx = 0; cap_wr = 0; cap_tx = 0; cap_pk = 0; cap_sloe = 1;
    cap_rx_data = '0; cap_fd = '0; cap_addr = '0;
    model_reset();
    forever begin
      @(posedge clk); #1;
      if (rst_n) begin
        if (cap_rd && ep2_q.size() > 0) void'(ep2_q.pop_front());
        if (cap_rx) rx_got.push_back(cap_rx_data);
        if (cap_wr) begin
          ep6_got.push_back(cap_fd);
          ep6_space--;
        end
        if (cap_tx && tx_q.size() > 0) void'(tx_q.pop_front());
        if (cap_pk) begin
          pkt_marks.push_back(ep6_got.size());
          pkt_addr.push_back(cap_addr);
        end
        if (cap_rd) begin
          dir_log.push_back(1'b0); rd_strobes++; cur_run++;
        end else if (cap_sloe && cur_run > 0) begin
          rd_runs.push_back(cur_run); cur_run = 0;
        end
        if (cap_wr) begin
          dir_log.push_back(1'b1); wr_strobes++;
        end
      end
      cap_rd = 0; cap_rx = 0; cap_wr = 0; cap_tx = 0; cap_pk = 0;
      cyc++;
      FLAGA    = ep2_q.size() > 0;
      FD_i     = FLAGA ? ep2_q[0] : 16'h0000;
      FLAGD    = ep6_space > 0;
      rx_ready = rdy_toggle ? cyc[0] : rdy_level;
      tx_valid = tx_en && tx_q.size() > 0;
      tx_data  = tx_valid ? tx_q[0] : 16'h0000;
      tx_flush = flush_req;
      flush_req = 0;
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        model_compare();
        cap_rd = !SLRD; cap_rx = rx_valid && rx_ready; cap_rx_data = rx_data;
        cap_wr = !SLWR; cap_fd = FD_o; cap_tx = tx_valid && tx_ready;
        cap_pk = !PKTEND; cap_addr = FIFOADR; cap_sloe = SLOE;
        model_advance();
      end
    end
  end

  task automatic wait_quiet(input int budget, input string tag);
    int n = 0;
    while (!(ep2_q.size() == 0 && tx_q.size() == 0 && m_dir == M_IDLE && !m_flush && !flush_req)
           && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check({tag, "_timeout"}, n < budget, 1);
    #2;
  endtask

  // Called at posedge+2 right after rst_n release, with EP2 non-empty and rx_ready=1.
  task automatic check_read_latency(input string tag);
    @(posedge clk); #2;
    check({tag, "_c1_sloe"}, SLOE, 1);
    check({tag, "_c1_addr"}, FIFOADR, 2'b00);
    @(posedge clk); #2;
    check({tag, "_c2_sloe"}, SLOE, 0);
    check({tag, "_c2_slrd"}, SLRD, 1);
    @(posedge clk); #2;
    check({tag, "_c3_slrd"}, SLRD, 0);
  endtask

  initial begin
    int rx_base, ep6_base, n;
    int runs_d[$];
    int runs_n[$];

    rst_n = 0;
    for (int i = 0; i < 10; i++) ep2_q.push_back(16'hA000 + 16'(i));
    repeat (3) @(posedge clk); #2;

    // Reset state with EP2 already holding data.
    check("rst_strobes", {SLRD, SLWR, SLOE, PKTEND}, 4'hF);
    check("rst_fd_oe", FD_oe, 0);
    check("rst_fifoadr", FIFOADR, 2'b00);
    check("rst_valid_ready", {rx_valid, tx_ready}, 2'b00);
    check("rst_fd_o", FD_o, 16'h0000);

    // Read 10 words, rx_ready toggling after the first word.
    rst_n = 1;
    check_read_latency("lat");
    rdy_toggle = 1;
    rd_runs.delete();
    wait_quiet(300, "read10");
    rdy_toggle = 0;
    check("read10_count", rx_got.size(), 10);
    check("read10_strobes", rd_strobes, 10);
    for (int i = 0; i < 10 && i < rx_got.size(); i++)
      check($sformatf("read10_word%0d", i), rx_got[i], 16'hA000 + 16'(i));
    check("read10_nruns", rd_runs.size(), 3);
    if (rd_runs.size() == 3) begin
      check("read10_run0", rd_runs[0], 4);
      check("read10_run1", rd_runs[1], 4);
      check("read10_run2", rd_runs[2], 2);
    end

    // Write 3 words then commit a short packet.
    for (int i = 0; i < 3; i++) tx_q.push_back(16'hB000 + 16'(i));
    flush_req = 1;
    wait_quiet(300, "flush");
    check("flush_words", ep6_got.size(), 3);
    check("flush_strobes", wr_strobes, 3);
    for (int i = 0; i < 3 && i < ep6_got.size(); i++)
      check($sformatf("flush_word%0d", i), ep6_got[i], 16'hB000 + 16'(i));
    check("flush_npkt", pkt_marks.size(), 1);
    if (pkt_marks.size() == 1) begin
      check("flush_pkt_pos", pkt_marks[0], 3);
      check("flush_pkt_addr", pkt_addr[0], 2'b10);
    end

    // EP6 fills after 2 words of 6; the rest must follow once space returns.
    ep6_space = 2;
    for (int i = 0; i < 6; i++) tx_q.push_back(16'hC000 + 16'(i));
    repeat (30) @(posedge clk); #2;
    check("stall_written", ep6_got.size(), 5);
    check("stall_pending", tx_q.size(), 4);
    ep6_space = 100;
    wait_quiet(300, "resume");
    check("resume_written", ep6_got.size(), 9);
    for (int i = 0; i < 6 && 3 + i < ep6_got.size(); i++)
      check($sformatf("resume_word%0d", i), ep6_got[3 + i], 16'hC000 + 16'(i));
    check("resume_npkt", pkt_marks.size(), 1);

    // Both sides saturated from reset: strict 4/4 alternation, read first.
    rst_n = 0;
    rx_base = rx_got.size();
    ep6_base = ep6_got.size();
    for (int i = 0; i < 16; i++) begin
      ep2_q.push_back(16'hD000 + 16'(i));
      tx_q.push_back(16'hE000 + 16'(i));
    end
    dir_log.delete();
    repeat (2) @(posedge clk); #2;
    rst_n = 1;
    wait_quiet(600, "sat");
    foreach (dir_log[i]) begin
      if (runs_d.size() == 0 || runs_d[runs_d.size() - 1] != int'(dir_log[i])) begin
        runs_d.push_back(int'(dir_log[i]));
        runs_n.push_back(1);
      end else begin
        runs_n[runs_n.size() - 1] += 1;
      end
    end
    check("sat_nruns", runs_n.size(), 8);
    for (int i = 0; i < 8 && i < runs_n.size(); i++) begin
      check($sformatf("sat_run%0d_dir", i), runs_d[i], i % 2);
      check($sformatf("sat_run%0d_len", i), runs_n[i], 4);
    end
    check("sat_rx_count", rx_got.size() - rx_base, 16);
    check("sat_tx_count", ep6_got.size() - ep6_base, 16);
    n = 0;
    for (int i = 0; i < 16 && rx_base + i < rx_got.size() && ep6_base + i < ep6_got.size(); i++)
      if (rx_got[rx_base + i] != 16'hD000 + 16'(i) || ep6_got[ep6_base + i] != 16'hE000 + 16'(i)) n++;
    check("sat_data_order_errors", n, 0);

    // Reset lands on the first read strobe of a burst.
    rx_base = rx_got.size();
    for (int i = 0; i < 8; i++) ep2_q.push_back(16'hF000 + 16'(i));
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (!SLRD) break;
      n++;
    end
    check("midrd_slrd_low", SLRD, 0);
    #2 rst_n = 0;
    #1;
    check("midrd_async_strobes", {SLRD, SLOE, SLWR, PKTEND}, 4'hF);
    check("midrd_async_fd_oe", FD_oe, 0);
    repeat (2) @(posedge clk); #2;
    rd_runs.delete();
    rst_n = 1;
    check_read_latency("relat");
    wait_quiet(300, "midrd");
    check("midrd_rx_count", rx_got.size() - rx_base, 8);
    for (int i = 0; i < 8 && rx_base + i < rx_got.size(); i++)
      check($sformatf("midrd_word%0d", i), rx_got[rx_base + i], 16'hF000 + 16'(i));
    check("midrd_nruns", rd_runs.size(), 2);
    if (rd_runs.size() == 2) check("midrd_first_run", rd_runs[0], 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/usb_fifo_sched.md
# usb_fifo_sched

Scheduler for the FX2LP slave-FIFO interface on the FPGA side of the USB path. Time-shares the single 16-bit FD bus between draining EP2 OUT (host→FPGA) and filling EP6 IN (FPGA→host). Drives SLRD/SLWR/SLOE/PKTEND/FIFOADR and the FD tristate enable. Presents valid/ready streams to the processing core (conv engine), with round-robin fairness and bounded bursts.

## Interface
- BURST_MAX, 256: max words moved per grant before re-arbitration (≥1, ≤65535)
- CLKOUT  in  1  system clock (FX2 CLKOUT); all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- FLAGA  in  1  EP2 OUT empty flag, active-low: 1 = EP2 holds data
- FLAGD  in  1  EP6 IN full flag, active-low: 1 = EP6 has space
- SLRD, SLWR, SLOE, PKTEND  out  1 each  FX2 strobes, active-low
- FIFOADR  out  2  endpoint select: 2'b00 = EP2, 2'b10 = EP6
- FD_i  in  16  FD pad input; FD_o  out  16  FD pad output; FD_oe  out  1  pad drive enable
- rx_data  out  16; rx_valid  out  1; rx_ready  in  1  EP2 word stream to core
- tx_data  in  16; tx_valid  in  1; tx_ready  out  1  core word stream to EP6
- tx_flush  in  1  one-cycle pulse: commit short EP6 packet after pending words

## Operation
- States: IDLE, SEL_RD, RD_OE, READ, SEL_WR, WRITE, PKTEND.
- Requests: rd_req = FLAGA; wr_req = tx_valid | flush_pend. flush_pend set by tx_flush, cleared on leaving PKTEND; a tx_flush coincident with the clear re-sets it.
- IDLE: both requests → grant opposite of last_grant (reset value: write, so read wins first); one request → grant it; none → stay. Grant read → SEL_RD, grant write → SEL_WR. last_grant updated on grant.
- SEL_RD (1 cycle): FIFOADR=00, SLOE=1, FD_oe=0 → RD_OE.
- RD_OE (1 cycle): FIFOADR=00, SLOE=0 (data settle) → READ.
- READ: SLOE=0; rx_data=FD_i; rx_valid=FLAGA; SLRD=~(FLAGA & rx_ready). Word transferred when rx_valid & rx_ready; burst count increments. Exit → IDLE when FLAGA=0 or count reaches BURST_MAX on a transfer.
- SEL_WR (1 cycle): FIFOADR=10, SLOE=1, FD_oe=0 (bus turnaround) → WRITE.
- WRITE: FD_oe=1; FD_o=tx_data; tx_ready=FLAGD; SLWR=~(tx_valid & FLAGD). Exit when FLAGD=0 or count reaches BURST_MAX → IDLE; when tx_valid=0: flush_pend → PKTEND, else IDLE.
- PKTEND (1 cycle): FIFOADR=10, FD_oe=1, PKTEND=0 → IDLE.
- Burst counter: 16-bit, cleared on entry to SEL_RD/SEL_WR; never wraps (exit at BURST_MAX).
- Invariants: SLOE=0 and FD_oe=1 never in the same cycle; SLRD=0 only in READ, SLWR=0 only in WRITE, PKTEND=0 only in PKTEND; FIFOADR changes only in SEL_RD/SEL_WR/IDLE.
- Outside READ: rx_valid=0. Outside WRITE: tx_ready=0.
- FIFOADR in IDLE holds its last value.

## Timing
- Reset (async assert, sync to edge on release): state=IDLE, last_grant=write, flush_pend=0, count=0; SLRD=SLWR=SLOE=PKTEND=1, FIFOADR=00, FD_oe=0, rx_valid=0, tx_ready=0, FD_o=0.
- Reset mid-burst: strobes deassert and FD_oe drops immediately (async); no partial word is counted.
- Strobes, rx_valid and tx_ready are combinational from state + FLAGA/FLAGD/handshakes; state, counter, FIFOADR are registered.
- Read latency: FLAGA rise in IDLE → first SLRD low 3 cycles later (IDLE→SEL_RD→RD_OE→READ). Steady state 1 word/cycle.
- Write latency: tx_valid in IDLE → first SLWR low 2 cycles later. Steady state 1 word/cycle.
- Direction switch costs ≥1 IDLE + select cycles; no cycle drives FD from both sides.
- FLAGA/FLAGD falling in the same cycle as a transfer: that strobe is already suppressed (combinational); no word lost or duplicated.

## Test plan
- Reset: hold rst_n=0 → all strobes 1, FD_oe=0, FIFOADR=00; release with FLAGA=1 → SLOE=0 at cycle 2, SLRD=0 at cycle 3.
- Read 10 words, rx_ready toggling 1/0 → exactly 10 rx transfers, SLRD low only when rx_ready=1, data order preserved; return to IDLE when FLAGA drops.
- Both sides saturated, BURST_MAX=4 → alternating bursts of exactly 4 reads and 4 writes, read first after reset; SLOE/FD_oe never overlap.
- Write 3 words then tx_flush → 3 SLWR pulses with FD_o=tx_data, then one PKTEND=0 cycle with FIFOADR=10.
- FLAGD drops mid-write burst → SLWR high same cycle, tx_ready=0, exit to IDLE; remaining words resumed on next grant without loss.
- rst_n asserted during READ → SLRD/SLOE return to 1 asynchronously; after release, restart from IDLE with count=0.
